count_run_ctrl: RTL and testbench
=================================

# count_run_ctrl

Run controller for the 4-bit free-running counter datapath. It accepts a run command over a valid/ready handshake. Each command holds a start value, a stop value and a direction. The block loads the counter, steps it once every PRESCALE cycles and stops when the stop value is reached. It also supports pause and abort, and reports completion so that a top-level sequencer or testbench can schedule successive count runs.

## Interface
- WIDTH, 4: counter width in bits.
- PRESCALE, 1: clock cycles per count step; legal range ≥ 1.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  the block can accept a command; high only in IDLE.
- cmd_start  in  WIDTH  value loaded on acceptance.
- cmd_stop  in  WIDTH  terminal value.
- cmd_dir  in  1  0 = count up, 1 = count down.
- pause  in  1  freezes stepping while high (only with the configuration macro).
- abort  in  1  ends the current run without signalling done.
- count  out  WIDTH  registered counter value.
- step  out  1  registered; high in the cycle after each count change caused by stepping.
- busy  out  1  high in RUN and HOLD.
- done  out  1  registered one-cycle completion pulse.

## Operation
- States: IDLE, RUN, HOLD, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, the command is accepted at the next edge: count ← cmd_start, the direction and stop value are latched, and the prescaler clears.
  - If cmd_start == cmd_stop, the next state is DONE (zero steps). Otherwise it is RUN.
- RUN:
  - The prescaler counts 0..PRESCALE-1.
  - When it wraps, count ← count ± 1 modulo 2^WIDTH and step = 1.
  - If the new count equals stop, the next state is DONE.
- Wrap-around is legal. Example, up from 14 to stop 1: counts 15, 0, 1 (3 steps). Down from 0: 0 → 15.
- HOLD:
  - Entered from RUN while pause = 1.
  - Count and prescaler are frozen.
  - Returns to RUN at the first edge with pause = 0; the prescaler resumes from its held value.
- DONE: lasts exactly one cycle with done = 1 and cmd_ready = 0, then returns to IDLE. The count holds the stop value.
- abort in RUN or HOLD:
  - The next state is IDLE; count holds its current value; done stays 0.
  - abort has priority over a step, over pause and over reaching stop in the same cycle.
- abort in IDLE or DONE is ignored.
- cmd_valid outside IDLE is ignored; there is no queuing.

## Timing
- Reset values: state IDLE, count 0, step 0, busy 0, done 0, prescaler 0. cmd_ready = 1 while in IDLE, including during reset.
- cmd_ready and busy are combinational decodes of the state register. All other outputs are registered.
- If a command is accepted at edge N:
  - count = cmd_start after edge N.
  - First step occurs at edge N + PRESCALE.
  - The k-th step occurs at edge N + k·PRESCALE, with no pause.
- done is high for the cycle following the edge that produced the stop value. A new command can be accepted one cycle later.
- Reset asserted mid-run returns all outputs to their reset values immediately.

## Configuration
- Macro: COUNT_RUN_CTRL_PAUSE_EN.
- Defined: pause works as described and HOLD exists.
- Undefined:
  - The pause port remains but is ignored.
  - HOLD is not implemented; RUN steps unconditionally until the stop value or abort.

## Structure
- Shared package counter_ctrl_pkg holds:
  - The state enum (IDLE, RUN, HOLD, DONE).
  - The direction constants DIR_UP = 1'b0 and DIR_DOWN = 1'b1.
- Sub-module step_counter is the counter datapath:
  - Inputs: clk, reset, load, load_val, en, dir.
  - Output: q.
  - It implements modulo-2^WIDTH up/down stepping with load.
- count_run_ctrl contains the FSM, the prescaler and the stop compare.

## Test plan
- Reset with no command: count = 0, cmd_ready = 1, busy = 0, done = 0; hold for 10 cycles and confirm all stay unchanged.
- PRESCALE = 1; command start 3, stop 7, up:
  - count sequence 3, 4, 5, 6, 7.
  - step high for 4 cycles.
  - done is a single pulse the cycle after count = 7.
  - IDLE follows.
- PRESCALE = 2; command start 1, stop 14, down:
  - Steps occur every 2 cycles through 0, 15, 14 (wrap-around).
  - done follows count = 14.
- Command start 5, stop 5: no step; done pulses the cycle after acceptance; count stays 5.
- Command start 0, stop 9, up; assert abort while count = 4 and a step is due:
  - count stays 4.
  - done never pulses.
  - cmd_ready returns the next cycle.
- With COUNT_RUN_CTRL_PAUSE_EN; command start 0, stop 6; hold pause for 5 cycles at count = 2:
  - count is frozen and busy = 1 during the pause.
  - Stepping resumes the cycle after pause drops.
  - done follows count = 6.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types for the count run controller: FSM state encoding and
// direction constants used by the controller and the counter datapath.
// Latency: n/a (types only). Backpressure: n/a.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } run_state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/step_counter.sv
// Counter datapath: modulo-2^WIDTH up/down counter with synchronous load.
// Latency: q updates on the edge where load or en is sampled high.
// Backpressure: none; load has priority over en.
// Ports: clk, reset (async, active-high), load, load_val, en, dir (0 up / 1 down), q.
module step_counter
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            // Natural wrap of the WIDTH-bit sum gives the modulo behaviour.
            q_d = (dir == DIR_DOWN) ? (q_q - ONE) : (q_q + ONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/count_run_ctrl.sv
// Run controller: accepts a start/stop/dir command, steps the counter every
// PRESCALE cycles until stop; first step PRESCALE edges after acceptance.
// Backpressure: cmd_ready high only in IDLE; commands elsewhere are dropped.
// Ports: clk, reset (async, active-high), cmd_valid/cmd_ready, cmd_start,
// cmd_stop, cmd_dir, pause, abort, count, step, busy, done.
// Optional macro COUNT_RUN_CTRL_PAUSE_EN enables pause/HOLD; otherwise pause is ignored.
module count_run_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_stop,
    input  logic             cmd_dir,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             busy,
    output logic             done
);

    localparam int               PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    run_state_e       state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] stop_q, stop_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             done_q, done_d;

    logic             ctr_load;
    logic             ctr_en;
    logic [WIDTH-1:0] ctr_q;
    logic [WIDTH-1:0] next_count;
    logic             pause_hit;

`ifdef COUNT_RUN_CTRL_PAUSE_EN
    assign pause_hit = pause;
`else
    logic pause_unused;
    assign pause_hit    = 1'b0;
    assign pause_unused = pause;
`endif

    // Value the counter will hold after a step; used for the stop compare so
    // DONE is entered on the same edge that produces the stop value.
    assign next_count = (dir_q == DIR_DOWN) ? (ctr_q - ONE) : (ctr_q + ONE);

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        stop_d   = stop_q;
        dir_d    = dir_q;
        step_d   = 1'b0;
        done_d   = 1'b0;
        ctr_load = 1'b0;
        ctr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    ctr_load = 1'b1;
                    stop_d   = cmd_stop;
                    dir_d    = cmd_dir;
                    presc_d  = '0;
                    if (cmd_start == cmd_stop) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // abort beats pause, which beats a due step.
                if (abort) begin
                    state_d = IDLE;
                end else if (pause_hit) begin
                    state_d = HOLD;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    ctr_en  = 1'b1;
                    step_d  = 1'b1;
                    if (next_count == stop_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end
`ifdef COUNT_RUN_CTRL_PAUSE_EN
            HOLD: begin
                // Prescaler keeps its value so the interrupted period resumes.
                if (abort) begin
                    state_d = IDLE;
                end else if (!pause_hit) begin
                    state_d = RUN;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            stop_q  <= '0;
            dir_q   <= DIR_UP;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            stop_q  <= stop_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    step_counter #(
        .WIDTH (WIDTH)
    ) u_step_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .load_val (cmd_start),
        .en       (ctr_en),
        .dir      (dir_q),
        .q        (ctr_q)
    );

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == RUN) || (state_q == HOLD);
    assign count     = ctr_q;
    assign step      = step_q;
    assign done      = done_q;

endmodule

// File: tb/tb_count_run_ctrl.sv
// Bench for count_run_ctrl: two instances (PRESCALE 1 and 2) share stimulus and
// are checked every cycle against a step-count model, plus literal checkpoints.
// Runs to completion on a fixed cycle schedule.
module tb_count_run_ctrl;

`ifdef COUNT_RUN_CTRL_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd_start = 4'd0;
    logic [3:0] cmd_stop = 4'd0;
    logic       cmd_dir = 1'b0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;

    logic       d_ready [2];
    logic [3:0] d_count [2];
    logic       d_step  [2];
    logic       d_busy  [2];
    logic       d_done  [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    count_run_ctrl #(.WIDTH(4), .PRESCALE(1)) dut_p1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(d_ready[0]),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_dir(cmd_dir),
        .pause(pause), .abort(abort), .count(d_count[0]), .step(d_step[0]),
        .busy(d_busy[0]), .done(d_done[0])
    );

    count_run_ctrl #(.WIDTH(4), .PRESCALE(2)) dut_p2 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(d_ready[1]),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_dir(cmd_dir),
        .pause(pause), .abort(abort), .count(d_count[1]), .step(d_step[1]),
        .busy(d_busy[1]), .done(d_done[1])
    );

    // Model: a run is "start plus (non-paused cycles / PRESCALE) steps", ending
    // when the step count equals the modular distance from start to stop.
    // Modes: 0 idle, 1 running, 2 paused, 3 completion cycle.
    int m_mode    [2] = '{0, 0};
    int m_start   [2] = '{0, 0};
    int m_dir     [2] = '{0, 0};
    int m_dist    [2] = '{0, 0};
    int m_elapsed [2] = '{0, 0};
    int m_count   [2] = '{0, 0};
    int m_step    [2] = '{0, 0};
    int m_done    [2] = '{0, 0};

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            int p;
            int steps;
            p = (i == 0) ? 1 : 2;
            if (reset) begin
                m_mode[i] = 0; m_count[i] = 0; m_step[i] = 0; m_done[i] = 0;
            end else begin
                m_step[i] = 0;
                m_done[i] = 0;
                case (m_mode[i])
                    0: if (cmd_valid) begin
                        m_start[i]   = int'(cmd_start);
                        m_dir[i]     = int'(cmd_dir);
                        m_count[i]   = int'(cmd_start);
                        m_elapsed[i] = 0;
                        m_dist[i]    = cmd_dir ? ((int'(cmd_start) - int'(cmd_stop)) & 15)
                                               : ((int'(cmd_stop) - int'(cmd_start)) & 15);
                        if (m_dist[i] == 0) begin
                            m_mode[i] = 3; m_done[i] = 1;
                        end else begin
                            m_mode[i] = 1;
                        end
                    end
                    1: if (abort) m_mode[i] = 0;
                       else if (PAUSE_EN && pause) m_mode[i] = 2;
                       else begin
                           m_elapsed[i]++;
                           if (m_elapsed[i] % p == 0) begin
                               steps      = m_elapsed[i] / p;
                               m_count[i] = (m_start[i] + (m_dir[i] ? -steps : steps)) & 15;
                               m_step[i]  = 1;
                               if (steps == m_dist[i]) begin
                                   m_mode[i] = 3; m_done[i] = 1;
                               end
                           end
                       end
                    2: if (abort) m_mode[i] = 0;
                       else if (!pause) m_mode[i] = 1;
                    default: m_mode[i] = 0;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("p%0d count", i + 1), 8'(d_count[i]), 8'(m_count[i]));
            chk($sformatf("p%0d step", i + 1), 8'(d_step[i]), 8'(m_step[i]));
            chk($sformatf("p%0d done", i + 1), 8'(d_done[i]), 8'(m_done[i]));
            chk($sformatf("p%0d busy", i + 1), 8'(d_busy[i]),
                8'(m_mode[i] == 1 || m_mode[i] == 2));
            chk($sformatf("p%0d ready", i + 1), 8'(d_ready[i]), 8'(m_mode[i] == 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic send(input logic [3:0] s, input logic [3:0] e, input logic d);
        cmd_valid = 1'b1; cmd_start = s; cmd_stop = e; cmd_dir = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        idle(3);
        reset = 1'b0;
        // Idle after reset: nothing may move for 10 cycles.
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("rst count", 8'(d_count[0]), 8'd0);
            chk("rst ready", 8'(d_ready[0]), 8'd1);
        end
        chk("rst busy", 8'(d_busy[1]), 8'd0);
        chk("rst done", 8'(d_done[1]), 8'd0);

        // Up 3 -> 7 at PRESCALE 1: 3,4,5,6,7 with a step per edge.
        send(4'd3, 4'd7, 1'b0);
        chk("up load", 8'(d_count[0]), 8'd3);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("up seq", 8'(d_count[0]), 8'(3 + k));
            chk("up step", 8'(d_step[0]), 8'd1);
        end
        chk("up done", 8'(d_done[0]), 8'd1);
        chk("up model pin", 8'(m_count[0]), 8'd7);
        tick();
        chk("up done drop", 8'(d_done[0]), 8'd0);
        chk("up ready", 8'(d_ready[0]), 8'd1);
        idle(6);

        // Down 1 -> 14 at PRESCALE 2: 0, 15, 14 every second edge.
        send(4'd1, 4'd14, 1'b1);
        chk("dn load", 8'(d_count[1]), 8'd1);
        tick(); chk("dn hold", 8'(d_count[1]), 8'd1); chk("dn nostep", 8'(d_step[1]), 8'd0);
        tick(); chk("dn s1", 8'(d_count[1]), 8'd0);
        tick(); chk("dn hold2", 8'(d_count[1]), 8'd0);
        tick(); chk("dn wrap", 8'(d_count[1]), 8'd15);
        tick();
        tick(); chk("dn s3", 8'(d_count[1]), 8'd14); chk("dn done", 8'(d_done[1]), 8'd1);
        idle(3);

        // Zero-step run.
        send(4'd5, 4'd5, 1'b0);
        chk("eq done", 8'(d_done[0]), 8'd1);
        chk("eq count", 8'(d_count[1]), 8'd5);
        chk("eq ready", 8'(d_ready[0]), 8'd0);
        tick();
        chk("eq idle", 8'(d_ready[1]), 8'd1);
        chk("eq step", 8'(d_step[0]), 8'd0);
        idle(2);

        // Abort at count 4 while a step is due.
        send(4'd0, 4'd9, 1'b0);
        idle(4);
        chk("ab at4", 8'(d_count[0]), 8'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab count", 8'(d_count[0]), 8'd4);
        chk("ab ready", 8'(d_ready[0]), 8'd1);
        chk("ab done", 8'(d_done[0]), 8'd0);
        chk("ab p2 count", 8'(d_count[1]), 8'd2);
        idle(4);
        abort = 1'b1; tick(); abort = 1'b0;   // abort in IDLE is ignored
        idle(2);

        // Pause at count 2 for 5 cycles.
        send(4'd0, 4'd6, 1'b0);
        idle(2);
        chk("ps at2", 8'(d_count[0]), 8'd2);
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (PAUSE_EN) begin
                chk("ps frozen", 8'(d_count[0]), 8'd2);
                chk("ps busy", 8'(d_busy[0]), 8'd1);
            end
        end
        pause = 1'b0;
        if (PAUSE_EN) begin
            tick(); chk("ps exit", 8'(d_count[0]), 8'd2);
            tick(); chk("ps resume", 8'(d_count[0]), 8'd3);
            idle(3);
            chk("ps end", 8'(d_count[0]), 8'd6);
            chk("ps done", 8'(d_done[0]), 8'd1);
        end else begin
            chk("nops end", 8'(d_count[0]), 8'd6);
        end
        idle(16);

        // Wrap up 14 -> 1; a command presented mid-run must be dropped.
        send(4'd14, 4'd1, 1'b0);
        chk("wr load", 8'(d_count[0]), 8'd14);
        tick();
        chk("wr 15", 8'(d_count[0]), 8'd15);
        cmd_valid = 1'b1; cmd_start = 4'd9; cmd_stop = 4'd9;
        tick(); chk("wr 0", 8'(d_count[0]), 8'd0);
        tick(); chk("wr 1", 8'(d_count[0]), 8'd1); chk("wr done", 8'(d_done[0]), 8'd1);
        cmd_valid = 1'b0;
        idle(8);

        // Reset in the middle of a run.
        send(4'd2, 4'd12, 1'b0);
        idle(2);
        reset = 1'b1;
        #1;
        chk("mr count", 8'(d_count[0]), 8'd0);
        chk("mr ready", 8'(d_ready[1]), 8'd1);
        chk("mr busy", 8'(d_busy[0]), 8'd0);
        idle(2);
        reset = 1'b0;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
